// File: rtl/neuron_mac.sv
// neuron_mac: streaming multiply-accumulate neuron front end (Q8.24).
// Optional macro NEURON_MAC_SAT_EN: saturate the 32-bit result instead of wrapping.
module neuron_mac #(
    parameter int ACC_W   = 48,
    parameter int COUNT_W = 10
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [31:0]        in_act,
    input  logic [31:0]        in_weight,
    input  logic               in_last,
    input  logic [31:0]        bias,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [31:0]        out_data,
    output logic [COUNT_W-1:0] out_count
);

    typedef enum logic [1:0] {
        S_ACC,
        S_DRAIN,
        S_OUT
    } state_t;

    localparam logic [COUNT_W-1:0] CNT_MAX = '1;
    localparam logic [COUNT_W-1:0] CNT_PRE = CNT_MAX - COUNT_W'(1);

    state_t state;
    state_t state_next;

    logic               in_xfer;
    logic               at_limit;
    logic               term_end;
    logic [COUNT_W-1:0] in_cnt;

    logic signed [63:0]      mul;
    logic signed [39:0]      mul_trunc;

    logic                    s1_valid;
    logic                    s1_last;
    logic signed [ACC_W-1:0] s1_prod;
    logic [31:0]             s1_bias;

    logic signed [ACC_W-1:0] acc;
    logic [COUNT_W-1:0]      acc_cnt;
    logic signed [ACC_W-1:0] acc_sum;
    logic signed [ACC_W-1:0] final_sum;
    logic [31:0]             conv_data;

    assign in_xfer  = in_valid && in_ready;
    assign at_limit = (in_cnt == CNT_PRE);
    // A term closes the neuron on in_last or when it fills the counter.
    assign term_end = in_valid && (in_last || at_limit);

    assign mul       = 64'($signed(in_act)) * 64'($signed(in_weight));
    assign mul_trunc = mul[63:24];

    assign acc_sum   = acc + s1_prod;
    assign final_sum = acc_sum + ACC_W'($signed(s1_bias));

`ifdef NEURON_MAC_SAT_EN
    localparam logic signed [31:0]      MAX32 = 32'sh7FFF_FFFF;
    localparam logic signed [31:0]      MIN32 = 32'sh8000_0000;
    localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'(MAX32);
    localparam logic signed [ACC_W-1:0] SAT_LO = ACC_W'(MIN32);

    // Clamp the wide sum into the signed 32-bit output range.
    always_comb begin
        conv_data = final_sum[31:0];
        if (final_sum > SAT_HI) begin
            conv_data = 32'h7FFF_FFFF;
        end else if (final_sum < SAT_LO) begin
            conv_data = 32'h8000_0000;
        end
    end
`else
    assign conv_data = final_sum[31:0];
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_ACC;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            S_ACC: begin
                in_ready = 1'b1;
                if (term_end) begin
                    state_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                state_next = S_OUT;
            end
            S_OUT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = S_ACC;
                end
            end
            default: begin
                state_next = S_ACC;
            end
        endcase
    end

    // Count accepted terms so the counter limit can force a last term.
    always_ff @(posedge clk) begin
        if (reset) begin
            in_cnt <= '0;
        end else if (in_xfer) begin
            if (in_last || at_limit) begin
                in_cnt <= '0;
            end else begin
                in_cnt <= in_cnt + COUNT_W'(1);
            end
        end
    end

    // Stage 1: register the truncated product, last flag and bias.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_last  <= 1'b0;
            s1_prod  <= '0;
            s1_bias  <= '0;
        end else begin
            s1_valid <= in_xfer;
            if (in_xfer) begin
                s1_prod <= ACC_W'(mul_trunc);
                s1_last <= in_last || at_limit;
                if (in_last || at_limit) begin
                    s1_bias <= bias;
                end
            end
        end
    end

    // Stage 2: accumulate, and on the last term publish the biased sum.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc       <= '0;
            acc_cnt   <= '0;
            out_data  <= '0;
            out_count <= '0;
        end else if (s1_valid) begin
            if (s1_last) begin
                out_data  <= conv_data;
                out_count <= acc_cnt + COUNT_W'(1);
                acc       <= '0;
                acc_cnt   <= '0;
            end else begin
                acc     <= acc_sum;
                acc_cnt <= acc_cnt + COUNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_neuron_mac.sv
// tb_neuron_mac: scoreboard bench for neuron_mac.
// Second instance uses COUNT_W=2 to reach the counter limit quickly.
module tb_neuron_mac;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, in_valid2;
    logic        in_ready, in_ready2;
    logic [31:0] in_act, in_weight, bias;
    logic        in_last;
    logic        out_valid, out_valid2;
    logic        out_ready;
    logic [31:0] out_data, out_data2;
    logic [9:0]  out_count;
    logic [1:0]  out_count2;

    always #5 clk = ~clk;

    neuron_mac dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_act(in_act), .in_weight(in_weight),
        .in_last(in_last), .bias(bias),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_count(out_count)
    );

    neuron_mac #(.COUNT_W(2)) dut2 (
        .clk(clk), .reset(reset),
        .in_valid(in_valid2), .in_ready(in_ready2),
        .in_act(in_act), .in_weight(in_weight),
        .in_last(in_last), .bias(bias),
        .out_valid(out_valid2), .out_ready(out_ready),
        .out_data(out_data2), .out_count(out_count2)
    );

    typedef struct {
        logic [31:0] d;
        int          c;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    int checks = 0;
    int errors = 0;

    logic signed [63:0] macc[2];
    int                 mcnt[2];

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h want %h", tag, got, want);
        end
    endtask

    function automatic logic [31:0] narrow(input logic signed [63:0] v);
`ifdef NEURON_MAC_SAT_EN
        if (v > 64'sh7FFF_FFFF) return 32'h7FFF_FFFF;
        if (v < -64'sh8000_0000) return 32'h8000_0000;
`endif
        return v[31:0];
    endfunction

    task automatic model_beat(input int sel, input logic [31:0] a,
                              input logic [31:0] w, input logic l,
                              input logic [31:0] b);
        logic signed [63:0] p;
        int                 lim;
        exp_t               e;
        p = 64'($signed(a)) * 64'($signed(w));
        macc[sel] += p >>> 24;
        mcnt[sel]++;
        lim = (sel == 0) ? 1023 : 3;
        if (l || mcnt[sel] == lim) begin
            e.d = narrow(macc[sel] + 64'($signed(b)));
            e.c = mcnt[sel];
            if (sel == 0) q0.push_back(e);
            else q1.push_back(e);
            macc[sel] = 0;
            mcnt[sel] = 0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input int sel, input logic [31:0] a,
                        input logic [31:0] w, input logic l,
                        input logic [31:0] b);
        int n;
        n = 0;
        in_act    = a;
        in_weight = w;
        in_last   = l;
        bias      = b;
        if (sel == 0) in_valid = 1'b1;
        else in_valid2 = 1'b1;
        while (!((sel == 0) ? in_ready : in_ready2) && n < 100) begin
            tick();
            n++;
        end
        check("accept", 32'(n < 100), 32'd1);
        model_beat(sel, a, w, l, b);
        tick();
        in_valid  = 1'b0;
        in_valid2 = 1'b0;
        in_last   = 1'($urandom);
        in_act    = $urandom;
        in_weight = $urandom;
        bias      = $urandom;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            in_act    = $urandom;
            in_weight = $urandom;
            tick();
        end
    endtask

    // Scoreboard for the default instance.
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin : mon0
            exp_t e;
            check("pending0", 32'(q0.size() != 0), 32'd1);
            if (q0.size() != 0) begin
                e = q0.pop_front();
                check("data0", out_data, e.d);
                check("count0", 32'(out_count), e.c);
            end
        end
    end

    // Scoreboard for the COUNT_W=2 instance.
    always @(negedge clk) begin
        if (!reset && out_valid2 && out_ready) begin : mon1
            exp_t e;
            check("pending1", 32'(q1.size() != 0), 32'd1);
            if (q1.size() != 0) begin
                e = q1.pop_front();
                check("data1", out_data2, e.d);
                check("count1", 32'(out_count2), e.c);
            end
        end
    end

    initial begin
        logic [31:0] held;
        int          gap;
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_valid2 = 1'b0;
        in_act    = '0;
        in_weight = '0;
        in_last   = 1'b0;
        bias      = '0;
        out_ready = 1'b1;
        macc[0]   = 0;
        macc[1]   = 0;
        mcnt[0]   = 0;
        mcnt[1]   = 0;
        tick();
        tick();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", out_data, 32'd0);
        check("rst_out_count", 32'(out_count), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        reset = 1'b0;
        tick();

        // Three back-to-back terms.
        beat(0, 32'h0100_0000, 32'h0080_0000, 1'b0, 32'h0);
        beat(0, 32'h0200_0000, 32'h0040_0000, 1'b0, 32'h0);
        beat(0, 32'hFF00_0000, 32'h00C0_0000, 1'b1, 32'h0020_0000);
        check("lat_k1", 32'(out_valid), 32'd0);
        tick();
        check("lat_k2", 32'(out_valid), 32'd1);
        check("sum3", out_data, 32'h0060_0000);
        check("cnt3", 32'(out_count), 32'd3);
        tick();

        // Single beat held by out_ready low.
        out_ready = 1'b0;
        beat(0, 32'h0100_0000, 32'h0100_0000, 1'b1, 32'h0);
        tick();
        held = out_data;
        check("one_data", out_data, 32'h0100_0000);
        for (int i = 0; i < 5; i++) begin
            check("stall_valid", 32'(out_valid), 32'd1);
            check("stall_data", out_data, held);
            check("stall_ready", 32'(in_ready), 32'd0);
            tick();
        end
        out_ready = 1'b1;
        tick();
        check("release_valid", 32'(out_valid), 32'd0);
        tick();
        check("release_ready", 32'(in_ready), 32'd1);

        // Overflow: wrap or saturate.
        for (int i = 0; i < 4; i++) begin
            beat(0, 32'h7F00_0000, 32'h0100_0000, 1'(i == 3), 32'h0);
        end
        tick();
`ifdef NEURON_MAC_SAT_EN
        check("ovf", out_data, 32'h7FFF_FFFF);
`else
        check("ovf", out_data, 32'hFC00_0000);
`endif
        idle(2);

        // Same three terms with bubbles.
        beat(0, 32'h0100_0000, 32'h0080_0000, 1'b0, 32'h0);
        gap = $urandom_range(1, 3);
        idle(gap);
        beat(0, 32'h0200_0000, 32'h0040_0000, 1'b0, 32'h0);
        gap = $urandom_range(1, 3);
        idle(gap);
        beat(0, 32'hFF00_0000, 32'h00C0_0000, 1'b1, 32'h0020_0000);
        tick();
        check("bub_sum", out_data, 32'h0060_0000);
        check("bub_cnt", 32'(out_count), 32'd3);
        idle(2);

        // Reset after two of three terms.
        beat(0, 32'h0100_0000, 32'h0080_0000, 1'b0, 32'h0);
        beat(0, 32'h0200_0000, 32'h0040_0000, 1'b0, 32'h0);
        reset   = 1'b1;
        macc[0] = 0;
        mcnt[0] = 0;
        tick();
        reset = 1'b0;
        check("abort_valid", 32'(out_valid), 32'd0);
        check("abort_data", out_data, 32'd0);
        check("abort_count", 32'(out_count), 32'd0);
        check("abort_ready", 32'(in_ready), 32'd1);
        idle(3);
        check("abort_quiet", 32'(out_valid), 32'd0);
        beat(0, 32'h0080_0000, 32'h0200_0000, 1'b1, 32'h0);
        tick();
        check("fresh_data", out_data, 32'h0100_0000);
        check("fresh_cnt", 32'(out_count), 32'd1);
        idle(2);

        // Counter limit on the narrow instance.
        beat(1, 32'h0100_0000, 32'h0100_0000, 1'b0, 32'h0);
        beat(1, 32'h0100_0000, 32'h0100_0000, 1'b0, 32'h0);
        beat(1, 32'h0100_0000, 32'h0100_0000, 1'b0, 32'h0);
        check("limit_ready", 32'(in_ready2), 32'd0);
        beat(1, 32'h0100_0000, 32'h0100_0000, 1'b0, 32'h0);
        beat(1, 32'h0100_0000, 32'h0100_0000, 1'b1, 32'h0);
        idle(10);

        check("q0_empty", 32'(q0.size()), 32'd0);
        check("q1_empty", 32'(q1.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
